// File: rtl/neighbor_validator.sv
// Classifies one query point as inlier/outlier by counting streamed candidate
// points within an L1 (Manhattan) radius, LANES candidates per accepted beat.
module neighbor_validator #(
  parameter int N     = 16,
  parameter int LANES = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [N-1:0]         point_x,
  input  logic [N-1:0]         point_y,
  input  logic [N-1:0]         point_z,
  input  logic [2*N-1:0]       point_cloud_size,
  input  logic [CNT_W-1:0]     threshold,
  input  logic [N-1:0]         search_radius,
  input  logic                 early_exit,
  input  logic                 exclude_zero,
  input  logic                 cp_valid,
  output logic                 cp_ready,
  input  logic [LANES-1:0]     cp_mask,
  input  logic [N*LANES-1:0]   cp_x,
  input  logic [N*LANES-1:0]   cp_y,
  input  logic [N*LANES-1:0]   cp_z,
  output logic                 busy,
  output logic                 done,
  output logic                 inlier,
  output logic                 outlier,
  output logic [CNT_W-1:0]     neighbor_count,
  output logic [2*N-1:0]       compared_count
);

  localparam int PW = $clog2(LANES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic [N-1:0]     px_reg, py_reg, pz_reg;
  logic [2*N-1:0]   size_reg;
  logic [CNT_W-1:0] thr_reg;
  logic [N-1:0]     rad_reg;
  logic             early_reg, excl_reg;

  logic             s1_valid_reg;
  logic [LANES-1:0] s1_mask_reg;
  logic [LANES-1:0] hits;

  logic [CNT_W-1:0] nc_reg, nc_next;
  logic [2*N-1:0]   cc_reg, cc_next;
  logic             inlier_reg, outlier_reg;

  logic             accept, capture, finish;
  logic [PW-1:0]    beat_cnt, hit_cnt;
  logic [CNT_W:0]   nc_sum;

  function automatic logic [PW-1:0] popcount(input logic [LANES-1:0] v);
    logic [PW-1:0] c;
    c = '0;
    for (int i = 0; i < LANES; i++) c = c + PW'(v[i]);
    return c;
  endfunction

  // Stage 1 registers the saturated per-lane distance; the hit decision is
  // combinational off stage 1 and lands in the counter (stage 2) one edge later.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : lane
      logic [N-1:0]   cx, cy, cz;
      logic [N-1:0]   dx, dy, dz;
      logic [N+1:0]   dsum;
      logic [N-1:0]   dsat;
      logic [N-1:0]   d_reg;

      assign cx   = cp_x[gi*N +: N];
      assign cy   = cp_y[gi*N +: N];
      assign cz   = cp_z[gi*N +: N];
      assign dx   = (cx >= px_reg) ? (cx - px_reg) : (px_reg - cx);
      assign dy   = (cy >= py_reg) ? (cy - py_reg) : (py_reg - cy);
      assign dz   = (cz >= pz_reg) ? (cz - pz_reg) : (pz_reg - cz);
      assign dsum = {2'b00, dx} + {2'b00, dy} + {2'b00, dz};
      assign dsat = (dsum[N+1:N] != 2'b00) ? {N{1'b1}} : dsum[N-1:0];

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          d_reg <= '0;
        end else if (accept) begin
          d_reg <= dsat;
        end
      end

      assign hits[gi] = s1_valid_reg && s1_mask_reg[gi] && (d_reg <= rad_reg) &&
                        !(excl_reg && (d_reg == '0));
    end
  endgenerate

  assign accept   = (state_reg == RUN) && cp_valid;
  assign beat_cnt = accept ? popcount(cp_mask) : '0;
  assign hit_cnt  = popcount(hits);
  assign cc_next  = cc_reg + (2*N)'(beat_cnt);
  assign nc_sum   = {1'b0, nc_reg} + (CNT_W+1)'(hit_cnt);
  assign nc_next  = nc_sum[CNT_W] ? {CNT_W{1'b1}} : nc_sum[CNT_W-1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Early exit looks at the post-update count so in-flight hits stop the scan
  // as soon as they are known.
  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          capture    = 1'b1;
          state_next = (point_cloud_size == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if ((cc_next >= size_reg) || (early_reg && (nc_next >= thr_reg))) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!s1_valid_reg) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      px_reg       <= '0;
      py_reg       <= '0;
      pz_reg       <= '0;
      size_reg     <= '0;
      thr_reg      <= '0;
      rad_reg      <= '0;
      early_reg    <= 1'b0;
      excl_reg     <= 1'b0;
      s1_valid_reg <= 1'b0;
      s1_mask_reg  <= '0;
      nc_reg       <= '0;
      cc_reg       <= '0;
      inlier_reg   <= 1'b0;
      outlier_reg  <= 1'b0;
    end else begin
      s1_valid_reg <= accept;
      s1_mask_reg  <= accept ? cp_mask : '0;
      if (capture) begin
        px_reg      <= point_x;
        py_reg      <= point_y;
        pz_reg      <= point_z;
        size_reg    <= point_cloud_size;
        thr_reg     <= threshold;
        rad_reg     <= search_radius;
        early_reg   <= early_exit;
        excl_reg    <= exclude_zero;
        nc_reg      <= '0;
        cc_reg      <= '0;
        // An empty cloud skips straight to DONE, so its verdict is set here.
        inlier_reg  <= (point_cloud_size == '0) && (threshold == '0);
        outlier_reg <= (point_cloud_size == '0) && (threshold != '0);
      end else begin
        nc_reg <= nc_next;
        cc_reg <= cc_next;
        if (finish) begin
          inlier_reg  <= (nc_next >= thr_reg);
          outlier_reg <= !(nc_next >= thr_reg);
        end
      end
    end
  end

  assign cp_ready       = (state_reg == RUN);
  assign busy           = (state_reg == RUN) || (state_reg == DRAIN);
  assign done           = (state_reg == DONE);
  assign inlier         = inlier_reg;
  assign outlier        = outlier_reg;
  assign neighbor_count = nc_reg;
  assign compared_count = cc_reg;

endmodule

// File: tb/tb_neighbor_validator.sv
// Directed bench for neighbor_validator: one task per scenario, inline checks.
module tb_neighbor_validator;

  localparam int N = 16;
  localparam int LANES = 8;
  localparam int CNT_W = 16;

  logic             clock, reset, start;
  logic [N-1:0]     point_x, point_y, point_z;
  logic [2*N-1:0]   point_cloud_size;
  logic [CNT_W-1:0] threshold;
  logic [N-1:0]     search_radius;
  logic             early_exit, exclude_zero;
  logic             cp_valid, cp_ready;
  logic [LANES-1:0] cp_mask;
  logic [N*LANES-1:0] cp_x, cp_y, cp_z;
  logic             busy, done, inlier, outlier;
  logic [CNT_W-1:0] neighbor_count;
  logic [2*N-1:0]   compared_count;

  int tests = 0;
  int fails = 0;

  neighbor_validator #(.N(N), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .start(start),
    .point_x(point_x), .point_y(point_y), .point_z(point_z),
    .point_cloud_size(point_cloud_size), .threshold(threshold),
    .search_radius(search_radius), .early_exit(early_exit),
    .exclude_zero(exclude_zero), .cp_valid(cp_valid), .cp_ready(cp_ready),
    .cp_mask(cp_mask), .cp_x(cp_x), .cp_y(cp_y), .cp_z(cp_z),
    .busy(busy), .done(done), .inlier(inlier), .outlier(outlier),
    .neighbor_count(neighbor_count), .compared_count(compared_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [2*N-1:0] size, input logic [CNT_W-1:0] thr,
                          input logic [N-1:0] rad, input logic early, input logic excl,
                          input logic [N-1:0] q);
    point_x = q; point_y = q; point_z = q;
    point_cloud_size = size; threshold = thr; search_radius = rad;
    early_exit = early; exclude_zero = excl;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Lanes below nhit sit at L1 distance dh along x from (1000,1000,1000), others at dm.
  task automatic fill_beat(input logic [LANES-1:0] mask, input int nhit, input int dh, input int dm);
    cp_mask = mask;
    for (int k = 0; k < LANES; k++) begin
      cp_x[k*N +: N] = N'(1000 + ((k < nhit) ? dh : dm));
      cp_y[k*N +: N] = N'(1000);
      cp_z[k*N +: N] = N'(1000);
    end
  endtask

  task automatic send_beat();
    bit ok;
    ok = 1'b0;
    cp_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (cp_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    cp_valid = 1'b0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL beat_accept: got no cp_ready within 10 cycles, required acceptance");
    end
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL done_timeout: got done=0 for 20 cycles, required done=1");
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    tests++;
    if ({cp_ready, busy, done, inlier, outlier} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b required 00000", {cp_ready, busy, done, inlier, outlier});
    end
    tests++;
    if (neighbor_count !== '0 || compared_count !== '0) begin
      fails++;
      $display("FAIL reset_counts: got nc=%0d cc=%0d required 0/0", neighbor_count, compared_count);
    end
    reset = 1'b1;
    tick(); tick();
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: got busy=%b done=%b required 0/0", busy, done);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_full_scan();
    do_start(32'd16, 16'd5, 16'd50, 1'b0, 1'b1, 16'd1000);
    tests++;
    if (busy !== 1'b1 || cp_ready !== 1'b1) begin
      fails++;
      $display("FAIL full_run_state: got busy=%b ready=%b required 1/1", busy, cp_ready);
    end
    fill_beat(8'hFF, 3, 10, 200);
    send_beat();
    send_beat();
    wait_done();
    tests++;
    if (neighbor_count !== 16'd6 || compared_count !== 32'd16) begin
      fails++;
      $display("FAIL full_counts: got nc=%0d cc=%0d required 6/16", neighbor_count, compared_count);
    end
    tests++;
    if (inlier !== 1'b1 || outlier !== 1'b0) begin
      fails++;
      $display("FAIL full_verdict: got in=%b out=%b required 1/0", inlier, outlier);
    end
    $display("[TB] full_scan nc=%0d cc=%0d inlier=%b", neighbor_count, compared_count, inlier);
    tick();
  endtask

  task automatic test_outlier();
    do_start(32'd24, 16'd5, 16'd50, 1'b0, 1'b1, 16'd1000);
    fill_beat(8'hFF, 1, 30, 300);
    for (int b = 0; b < 3; b++) send_beat();
    wait_done();
    tests++;
    if (neighbor_count !== 16'd3 || compared_count !== 32'd24) begin
      fails++;
      $display("FAIL outlier_counts: got nc=%0d cc=%0d required 3/24", neighbor_count, compared_count);
    end
    tests++;
    if (outlier !== 1'b1 || inlier !== 1'b0) begin
      fails++;
      $display("FAIL outlier_verdict: got in=%b out=%b required 0/1", inlier, outlier);
    end
    tick();
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse: got done=%b one cycle later, required 0", done);
    end
    tick(); tick();
    tests++;
    if (neighbor_count !== 16'd3 || outlier !== 1'b1 || compared_count !== 32'd24) begin
      fails++;
      $display("FAIL hold_after_done: got nc=%0d out=%b cc=%0d required 3/1/24",
               neighbor_count, outlier, compared_count);
    end
    $display("[TB] outlier nc=%0d outlier=%b", neighbor_count, outlier);
  endtask

  task automatic test_early_exit();
    int beats;
    beats = 0;
    do_start(32'd64, 16'd5, 16'd50, 1'b1, 1'b1, 16'd1000);
    fill_beat(8'hFF, 8, 7, 7);
    cp_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (!cp_ready) break;
      beats++;
      tick();
    end
    cp_valid = 1'b0;
    tests++;
    if (beats < 1 || beats > 2) begin
      fails++;
      $display("FAIL early_beats: got %0d beats accepted, required 1..2", beats);
    end
    wait_done();
    tests++;
    if (neighbor_count !== 16'(8*beats) || compared_count !== 32'(8*beats)) begin
      fails++;
      $display("FAIL early_counts: got nc=%0d cc=%0d required %0d/%0d",
               neighbor_count, compared_count, 8*beats, 8*beats);
    end
    tests++;
    if (inlier !== 1'b1 || compared_count >= 32'd64) begin
      fails++;
      $display("FAIL early_verdict: got in=%b cc=%0d required 1 and cc<64", inlier, compared_count);
    end
    $display("[TB] early_exit beats=%0d nc=%0d", beats, neighbor_count);
    tick();
  endtask

  task automatic test_boundaries();
    // lane0 d=50, lane1 d=51, lane2 d=0, lane3 d=25 split over axes; 4..7 masked off
    for (int pass = 0; pass < 2; pass++) begin
      do_start(32'd4, 16'd1, 16'd50, 1'b0, (pass == 0), 16'd1000);
      fill_beat(8'h0F, 0, 0, 0);
      cp_x[0*N +: N] = 16'd1050;
      cp_x[1*N +: N] = 16'd949;
      cp_x[3*N +: N] = 16'd1010;
      cp_y[3*N +: N] = 16'd990;
      cp_z[3*N +: N] = 16'd1005;
      send_beat();
      wait_done();
      tests++;
      if (neighbor_count !== ((pass == 0) ? 16'd2 : 16'd3) || compared_count !== 32'd4) begin
        fails++;
        $display("FAIL bound_excl%0d: got nc=%0d cc=%0d required %0d/4",
                 1 - pass, neighbor_count, compared_count, (pass == 0) ? 2 : 3);
      end
      $display("[TB] boundaries exclude_zero=%0d nc=%0d", 1 - pass, neighbor_count);
      tick();
    end
    // all-axis 0xFFFF must saturate to 0xFFFF (> radius 0xFFFE); lane1 d=0xFFFD hits
    do_start(32'd2, 16'd1, 16'hFFFE, 1'b0, 1'b1, 16'd0);
    cp_mask = 8'h03;
    cp_x = '0; cp_y = '0; cp_z = '0;
    cp_x[0*N +: N] = 16'hFFFF;
    cp_y[0*N +: N] = 16'hFFFF;
    cp_z[0*N +: N] = 16'hFFFF;
    cp_x[1*N +: N] = 16'hFFFD;
    send_beat();
    wait_done();
    tests++;
    if (neighbor_count !== 16'd1) begin
      fails++;
      $display("FAIL saturation: got nc=%0d required 1", neighbor_count);
    end
    $display("[TB] saturation nc=%0d", neighbor_count);
    tick();
  endtask

  task automatic test_edges();
    do_start(32'd0, 16'd5, 16'd50, 1'b0, 1'b1, 16'd1000);
    tests++;
    if (done !== 1'b1 || outlier !== 1'b1 || inlier !== 1'b0 || compared_count !== '0) begin
      fails++;
      $display("FAIL empty_cloud: got done=%b in=%b out=%b cc=%0d required 1/0/1/0",
               done, inlier, outlier, compared_count);
    end
    tick();
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL empty_pulse: got done=%b required 0", done);
    end
    do_start(32'd0, 16'd0, 16'd50, 1'b0, 1'b1, 16'd1000);
    tests++;
    if (done !== 1'b1 || inlier !== 1'b1 || outlier !== 1'b0) begin
      fails++;
      $display("FAIL empty_thr0: got done=%b in=%b out=%b required 1/1/0", done, inlier, outlier);
    end
    tick();
    fill_beat(8'hFF, 8, 1, 1);
    cp_valid = 1'b1;
    tick(); tick(); tick();
    cp_valid = 1'b0;
    tests++;
    if (compared_count !== '0 || neighbor_count !== '0 || cp_ready !== 1'b0) begin
      fails++;
      $display("FAIL valid_no_ready: got cc=%0d nc=%0d ready=%b required 0/0/0",
               compared_count, neighbor_count, cp_ready);
    end
    $display("[TB] edges checked");
  endtask

  task automatic test_reset_mid_run();
    do_start(32'd24, 16'd5, 16'd50, 1'b0, 1'b1, 16'd1000);
    fill_beat(8'hFF, 4, 5, 100);
    send_beat();
    reset = 1'b0;
    #1;
    tests++;
    if ({cp_ready, busy, done, inlier, outlier} !== 5'b0 ||
        neighbor_count !== '0 || compared_count !== '0) begin
      fails++;
      $display("FAIL mid_reset: got flags=%b nc=%0d cc=%0d required 00000/0/0",
               {cp_ready, busy, done, inlier, outlier}, neighbor_count, compared_count);
    end
    tick();
    reset = 1'b1;
    tick();
    do_start(32'd16, 16'd5, 16'd50, 1'b0, 1'b1, 16'd1000);
    fill_beat(8'hFF, 4, 5, 100);
    send_beat();
    send_beat();
    wait_done();
    tests++;
    if (neighbor_count !== 16'd8 || compared_count !== 32'd16 || inlier !== 1'b1) begin
      fails++;
      $display("FAIL after_reset: got nc=%0d cc=%0d in=%b required 8/16/1",
               neighbor_count, compared_count, inlier);
    end
    $display("[TB] reset_mid_run nc=%0d cc=%0d", neighbor_count, compared_count);
    tick();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; cp_valid = 1'b0; cp_mask = '0;
    cp_x = '0; cp_y = '0; cp_z = '0;
    point_x = '0; point_y = '0; point_z = '0;
    point_cloud_size = '0; threshold = '0; search_radius = '0;
    early_exit = 1'b0; exclude_zero = 1'b0;
    #2;
    test_reset();
    test_full_scan();
    test_outlier();
    test_early_exit();
    test_boundaries();
    test_edges();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/neighbor_validator.md
NEIGHBOR_VALIDATOR -- requirements
Module: neighbor_validator

Interface
REQ-001 SHALL have parameter N, default 16, coordinate and distance width in bits.
REQ-002 SHALL have parameter LANES, default 8, number of candidate points compared per beat.
REQ-003 SHALL have parameter CNT_W, default 16, width of the neighbor and comparison counters.
REQ-004 SHALL have ports: clock  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: start  in  1  begin classification of one query point (sampled in IDLE only).
REQ-007 SHALL have ports: point_x/point_y/point_z  in  N each  query point coordinates, captured on start.
REQ-008 SHALL have ports: point_cloud_size  in  2N  candidates to compare; threshold  in  CNT_W  neighbors required for an inlier; search_radius  in  N  inclusive radius; early_exit  in  1  stop once threshold is met; exclude_zero  in  1  ignore zero-distance matches (self); all captured on start.
REQ-009 SHALL have ports: cp_valid  in  1, cp_ready  out  1, cp_mask  in  LANES  per-lane valid, cp_x/cp_y/cp_z  in  N*LANES  packed candidates, lane k at bits [(k+1)N-1:kN].
REQ-010 SHALL have ports: busy  out  1; done  out  1  one-cycle pulse; inlier  out  1; outlier  out  1; neighbor_count  out  CNT_W; compared_count  out  2N.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DRAIN, DONE; busy=1 in RUN and DRAIN.
REQ-012 IDLE: on start=1, SHALL capture all REQ-007/008 inputs, clear both counters, clear inlier/outlier, and go to RUN.
REQ-013 IDLE with captured point_cloud_size=0: SHALL go directly from start to DONE, with no beat accepted.
REQ-014 RUN: cp_ready SHALL be 1; a beat is accepted when cp_valid&&cp_ready; cp_ready SHALL be 0 in all other states.
REQ-015 On each accepted beat, compared_count SHALL increase by popcount(cp_mask) in the same cycle.
REQ-016 Stage 1 (the cycle after acceptance): per lane, register d=|dx|+|dy|+|dz|, computed at N+2 bits and saturated to 2^N-1, plus the lane mask bit.
REQ-017 Stage 2: lane hit = mask && d<=search_radius && !(exclude_zero && d==0); neighbor_count SHALL add popcount(hits), saturating at 2^CNT_W-1.
REQ-018 Latency: a beat accepted at cycle t SHALL be reflected in neighbor_count by the end of cycle t+2.
REQ-019 RUN->DRAIN SHALL occur when compared_count (after update) >= point_cloud_size, or when early_exit=1 and neighbor_count >= threshold.
REQ-020 Beats accepted before cp_ready drops SHALL still be counted, including after an early exit.
REQ-021 DRAIN SHALL last until both pipeline stages hold no valid beat (at most 2 cycles), then go to DONE.
REQ-022 DONE: SHALL pulse done for exactly 1 cycle; inlier=(neighbor_count>=threshold), outlier=!inlier; then return to IDLE.
REQ-023 inlier, outlier and both counters SHALL hold after DONE until the next accepted start.
REQ-024 threshold=0 SHALL give inlier=1.
REQ-025 start while busy SHALL be ignored.
REQ-026 Candidates beyond point_cloud_size inside the final beat SHALL still be counted; masking them is the producer's job via cp_mask.

Reset
REQ-027 While reset=0, SHALL force state IDLE, clear both pipeline stages, and drive cp_ready, busy, done, inlier, outlier = 0, with both counters 0; this applies in any state, mid-operation included.
REQ-028 After reset deasserts, SHALL take no action until the next start.

Verification
REQ-029 Full scan: LANES=8, cloud_size=16, threshold=5, radius=50, 2 beats each with 3 lanes at d=10 -> done, neighbor_count=6, compared_count=16, inlier=1.
REQ-030 Outlier: cloud_size=24, 3 beats, 1 hit each, threshold=5 -> neighbor_count=3, outlier=1, done 1 cycle only.
REQ-031 Early exit: early_exit=1, threshold=5, back-to-back beats with 8 hits each, cloud_size=64 -> cp_ready drops after 1-2 beats; all accepted hits counted; inlier=1; compared_count<64.
REQ-032 Boundaries: d==radius counted; d==radius+1 not counted; lane at identical coordinates ignored when exclude_zero=1, counted when exclude_zero=0; coordinate diff 0xFFFF on all axes saturates to 0xFFFF.
REQ-033 Edges: cloud_size=0 -> done 1 cycle after start, outlier=1 (inlier=1 if threshold=0); cp_valid with cp_ready low -> no count change.
REQ-034 Reset mid-RUN: assert reset=0 after 1 beat -> all outputs 0 immediately; a fresh start yields correct counts.
